// File: rtl/beta_pkg.sv
// Shared definitions for the Beta core: opcodes, trap vectors and FSM states.
package beta_pkg;
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADDR_VEC = 32'h8000_0008;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // ALU function codes live in op[3:0]; op[5]=1 selects ALU, op[4]=1 the literal form.
  localparam logic [3:0] FN_ADD   = 4'h0;
  localparam logic [3:0] FN_SUB   = 4'h1;
  localparam logic [3:0] FN_MUL   = 4'h2;
  localparam logic [3:0] FN_CMPEQ = 4'h4;
  localparam logic [3:0] FN_CMPLT = 4'h5;
  localparam logic [3:0] FN_CMPLE = 4'h6;
  localparam logic [3:0] FN_AND   = 4'h8;
  localparam logic [3:0] FN_OR    = 4'h9;
  localparam logic [3:0] FN_XOR   = 4'hA;
  localparam logic [3:0] FN_SHL   = 4'hC;
  localparam logic [3:0] FN_SHR   = 4'hD;
  localparam logic [3:0] FN_SRA   = 4'hE;

  localparam logic [4:0] REG_XP   = 5'd30;
  localparam logic [4:0] REG_ZERO = 5'd31;

  typedef enum logic {RUN = 1'b0, MISS_WAIT = 1'b1} state_t;

  function automatic logic aluFnLegal(input logic [3:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_MUL, FN_CMPEQ, FN_CMPLT, FN_CMPLE,
      FN_AND, FN_OR, FN_XOR, FN_SHL, FN_SHR, FN_SRA: aluFnLegal = 1'b1;
      default: aluFnLegal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/beta_dcache.sv
// Direct-mapped, one-word-per-line, write-through data read cache.
module beta_dcache #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] wordAddr,
  input  logic        rdEn,
  output logic        hit,
  output logic [31:0] rdData,
  input  logic        wrEn,
  input  logic [31:0] wrData,
  input  logic        fillEn,
  input  logic [31:0] fillData
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  logic [TW-1:0]    tagMem  [LINES];
  logic [31:0]      dataMem [LINES];
  logic [LINES-1:0] valid;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;

  assign idx    = wordAddr[IW-1:0];
  assign tag    = wordAddr[29:IW];
  assign hit    = rdEn & valid[idx] & (tagMem[idx] == tag);
  assign rdData = dataMem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (wrEn | fillEn) valid[idx] <= 1'b1;
  end

  // Stores allocate as well as update, so a later load of the same word hits.
  always_ff @(posedge clk) begin
    if (wrEn | fillEn) begin
      tagMem[idx]  <= tag;
      dataMem[idx] <= fillEn ? fillData : wrData;
    end
  end
endmodule

// File: rtl/beta_cpu.sv
// Single-cycle Beta core; load misses stall in MISS_WAIT on a 4-phase ready/done handshake.
module beta_cpu
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC   = DEF_ILLOP_VEC,
  parameter logic [31:0] XADDR_VEC   = DEF_XADDR_VEC,
  parameter int          CACHE_LINES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic [31:0] id,
  input  logic [31:0] memReadData,
  input  logic        MemReadReady,
  output logic [31:0] ia,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemReadDone,
  output logic        MemHit
);
  state_t      state, stateNext;
  logic [31:0] iaNext;
  logic        doneNext;
  logic [31:0] regs [32];
  logic [5:0]  op;
  logic [4:0]  rc, ra, rb, rbSel, wAddr;
  logic [31:0] lit, pcInc, brTarget, raData, rbData, aluB, aluOut, cacheData, wData;
  logic        isAlu, isLd, isSt, legal, irqTake, wEn, fillEn;

  assign op    = id[31:26];
  assign rc    = id[25:21];
  assign ra    = id[20:16];
  assign rb    = id[15:11];
  assign lit   = {{16{id[15]}}, id[15:0]};
  assign pcInc = {ia[31], ia[30:0] + 31'd4};
  assign brTarget = {ia[31], pcInc[30:0] + {lit[28:0], 2'b00}};

  // ST needs Rc as its data operand, so the second read port switches to Rc.
  assign rbSel  = (op == OP_ST) ? rc : rb;
  assign raData = (ra == REG_ZERO) ? '0 : regs[ra];
  assign rbData = (rbSel == REG_ZERO) ? '0 : regs[rbSel];

  assign isAlu = op[5] & aluFnLegal(op[3:0]);
  assign isLd  = (op == OP_LD) | (op == OP_LDR);
  assign isSt  = (op == OP_ST);
  assign legal = isAlu | isLd | isSt | (op == OP_JMP) | (op == OP_BEQ) | (op == OP_BNE);
  assign aluB  = op[4] ? lit : rbData;

  assign irqTake      = (state == RUN) & irq & ~ia[31];
  assign memAddr      = (op == OP_LDR) ? brTarget : raData + lit;
  assign memWriteData = rbData;
  assign MemRead      = isLd & ~irqTake;
  assign MemWrite     = isSt & (state == RUN) & ~irqTake & ~reset;

  always_comb begin
    aluOut = '0;
    case (op[3:0])
      FN_ADD:   aluOut = raData + aluB;
      FN_SUB:   aluOut = raData - aluB;
      FN_MUL:   aluOut = raData * aluB;
      FN_CMPEQ: aluOut = {31'b0, raData == aluB};
      FN_CMPLT: aluOut = {31'b0, $signed(raData) < $signed(aluB)};
      FN_CMPLE: aluOut = {31'b0, $signed(raData) <= $signed(aluB)};
      FN_AND:   aluOut = raData & aluB;
      FN_OR:    aluOut = raData | aluB;
      FN_XOR:   aluOut = raData ^ aluB;
      FN_SHL:   aluOut = raData << aluB[4:0];
      FN_SHR:   aluOut = raData >> aluB[4:0];
      FN_SRA:   aluOut = $signed(raData) >>> aluB[4:0];
      default:  aluOut = '0;
    endcase
  end

  always_comb begin
    stateNext = state;
    iaNext    = ia;
    doneNext  = MemReadDone & MemReadReady;
    wEn       = 1'b0;
    wAddr     = rc;
    wData     = aluOut;
    fillEn    = 1'b0;
    case (state)
      RUN: begin
        if (irqTake || !legal) begin
          wEn    = 1'b1;
          wAddr  = REG_XP;
          wData  = pcInc;
          iaNext = irqTake ? XADDR_VEC : ILLOP_VEC;
        end else if (MemRead && !MemHit) begin
          stateNext = MISS_WAIT;
        end else begin
          iaNext = pcInc;
          wEn    = !isSt;
          if (isLd) wData = cacheData;
          else if (!isAlu) wData = pcInc;
          if (op == OP_JMP) iaNext = {ia[31] & raData[31], raData[30:2], 2'b00};
          if ((op == OP_BEQ && raData == '0) || (op == OP_BNE && raData != '0)) iaNext = brTarget;
        end
      end
      MISS_WAIT: begin
        // A done still high from the previous load masks a stale ready.
        if (MemReadReady && !MemReadDone) begin
          wEn       = 1'b1;
          wData     = memReadData;
          fillEn    = 1'b1;
          iaNext    = pcInc;
          doneNext  = 1'b1;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      ia          <= RESET_VEC;
      MemReadDone <= 1'b0;
    end else begin
      state       <= stateNext;
      ia          <= iaNext;
      MemReadDone <= doneNext;
    end
  end

  always_ff @(posedge clk) begin
    if (wEn && !reset && wAddr != REG_ZERO) regs[wAddr] <= wData;
  end

  beta_dcache #(.LINES(CACHE_LINES)) uCache (
    .clk      (clk),
    .rst      (reset),
    .wordAddr (memAddr[31:2]),
    .rdEn     (MemRead),
    .hit      (MemHit),
    .rdData   (cacheData),
    .wrEn     (MemWrite),
    .wrData   (memWriteData),
    .fillEn   (fillEn),
    .fillData (memReadData)
  );
endmodule

// File: tb/tb_beta_cpu.sv
// Cycle-by-cycle vector bench for beta_cpu; register contents are observed through later stores.
module tb_beta_cpu;
  typedef struct packed {
    logic [31:0] ia;
    logic        rd;
    logic        wr;
    logic        hit;
    logic        done;
    logic [31:0] addr;
    logic        chkAddr;
    logic [31:0] wdata;
    logic        chkWdata;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        irqIn;
    logic        rdy;
    logic [31:0] rdata;
    exp_t        exp;
  } vec_t;

  logic        clk, reset, irq, MemReadReady;
  logic [31:0] id, memReadData;
  logic [31:0] ia, memAddr, memWriteData;
  logic        MemWrite, MemRead, MemReadDone, MemHit;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  beta_cpu dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .id           (id),
    .memReadData  (memReadData),
    .MemReadReady (MemReadReady),
    .ia           (ia),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadDone  (MemReadDone),
    .MemHit       (MemHit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] opc(input logic [5:0] o, input logic [4:0] c, input logic [4:0] a,
                                      input logic [15:0] l);
    return {o, c, a, l};
  endfunction

  function automatic logic [31:0] opr(input logic [5:0] o, input logic [4:0] c, input logic [4:0] a,
                                      input logic [4:0] b);
    return {o, c, a, b, 11'b0};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, stepNo, act, expv);
    end
  endtask

  // driver helpers
  task automatic add(input logic [31:0] instr, input logic irqIn, input logic rdy, input logic [31:0] rdata,
                     input logic [31:0] eIa, input logic rd, input logic wr, input logic hit, input logic done,
                     input logic [31:0] addr, input logic chkA, input logic [31:0] wdata, input logic chkW);
    vec_t v;
    v.instr = instr; v.irqIn = irqIn; v.rdy = rdy; v.rdata = rdata;
    v.exp = '{ia: eIa, rd: rd, wr: wr, hit: hit, done: done, addr: addr, chkAddr: chkA,
              wdata: wdata, chkWdata: chkW};
    vecs.push_back(v);
  endtask

  task automatic aluV(input logic [31:0] instr, input logic [31:0] eIa);
    add(instr, 1'b0, 1'b0, 32'h0, eIa, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic stV(input logic [31:0] instr, input logic [31:0] eIa, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic irqIn = 1'b0, input logic done = 1'b0,
                     input logic rdy = 1'b0);
    add(instr, irqIn, rdy, 32'h0, eIa, 1'b0, 1'b1, 1'b0, done, addr, 1'b1, wdata, 1'b1);
  endtask

  task automatic ldV(input logic [31:0] instr, input logic [31:0] eIa, input logic [31:0] addr,
                     input logic hit, input logic rdy, input logic [31:0] rdata, input logic done);
    add(instr, 1'b0, rdy, rdata, eIa, 1'b1, 1'b0, hit, done, addr, 1'b1, 32'h0, 1'b0);
  endtask

  // scoreboard
  task automatic checkOutputs();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", stepNo);
      return;
    end
    e = exp_q.pop_front();
    cmp("ia", ia, e.ia);
    cmp("MemRead", {31'b0, MemRead}, {31'b0, e.rd});
    cmp("MemWrite", {31'b0, MemWrite}, {31'b0, e.wr});
    cmp("MemHit", {31'b0, MemHit}, {31'b0, e.hit});
    cmp("MemReadDone", {31'b0, MemReadDone}, {31'b0, e.done});
    if (e.chkAddr) cmp("memAddr", memAddr, e.addr);
    if (e.chkWdata) cmp("memWriteData", memWriteData, e.wdata);
  endtask

  task automatic apply(input vec_t v);
    id = v.instr; irq = v.irqIn; MemReadReady = v.rdy; memReadData = v.rdata;
    exp_q.push_back(v.exp);
    #2;
    checkOutputs();
    @(negedge clk);
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      stepNo++;
      apply(vecs[i]);
    end
    vecs.delete();
  endtask

  initial begin
    reset = 1'b1; irq = 1'b0; MemReadReady = 1'b0; memReadData = '0; id = '0;
    repeat (2) @(negedge clk);
    id = opc(6'h19, 5'd1, 5'd31, 16'h0010);
    #2;
    cmp("reset_ia", ia, 32'h8000_0000);
    cmp("reset_MemWrite", {31'b0, MemWrite}, 32'h0);
    cmp("reset_done", {31'b0, MemReadDone}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ALU, store and cache-hit load
    aluV(opc(6'h30, 5'd1, 5'd31, 16'd5), 32'h8000_0000);
    stV(opc(6'h19, 5'd1, 5'd31, 16'h0010), 32'h8000_0004, 32'h10, 32'd5);
    ldV(opc(6'h18, 5'd2, 5'd31, 16'h0010), 32'h8000_0008, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0);
    stV(opc(6'h19, 5'd2, 5'd31, 16'h0014), 32'h8000_000C, 32'h14, 32'd5);
    aluV(opc(6'h30, 5'd3, 5'd31, 16'd7), 32'h8000_0010);
    aluV(opr(6'h21, 5'd4, 5'd3, 5'd1), 32'h8000_0014);
    stV(opc(6'h19, 5'd4, 5'd31, 16'h0020), 32'h8000_0018, 32'h20, 32'd2);
    aluV(opc(6'h32, 5'd5, 5'd3, 16'hFFFD), 32'h8000_001C);
    stV(opc(6'h19, 5'd5, 5'd31, 16'h0020), 32'h8000_0020, 32'h20, 32'hFFFF_FFEB);
    aluV(opc(6'h35, 5'd6, 5'd5, 16'h0000), 32'h8000_0024);
    stV(opc(6'h19, 5'd6, 5'd31, 16'h0020), 32'h8000_0028, 32'h20, 32'd1);
    aluV(opc(6'h3E, 5'd7, 5'd5, 16'd1), 32'h8000_002C);
    stV(opc(6'h19, 5'd7, 5'd31, 16'h0020), 32'h8000_0030, 32'h20, 32'hFFFF_FFF5);
    aluV(opc(6'h3C, 5'd8, 5'd3, 16'd4), 32'h8000_0034);
    stV(opc(6'h19, 5'd8, 5'd3, 16'h0004), 32'h8000_0038, 32'h0B, 32'h70);
    aluV(opc(6'h3D, 5'd8, 5'd5, 16'd28), 32'h8000_003C);
    stV(opc(6'h19, 5'd8, 5'd31, 16'h0020), 32'h8000_0040, 32'h20, 32'hF);

    // single miss: ready held off for five cycles, then data arrives
    for (int i = 0; i < 5; i++)
      ldV(opc(6'h18, 5'd9, 5'd31, 16'h0040), 32'h8000_0044, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    ldV(opc(6'h18, 5'd9, 5'd31, 16'h0040), 32'h8000_0044, 32'h40, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    stV(opc(6'h19, 5'd9, 5'd31, 16'h0024), 32'h8000_0048, 32'h24, 32'hDEAD, 1'b0, 1'b1, 1'b1);
    ldV(opc(6'h18, 5'd12, 5'd31, 16'h0040), 32'h8000_004C, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
    stV(opc(6'h19, 5'd12, 5'd31, 16'h0024), 32'h8000_0050, 32'h24, 32'hDEAD);

    // back-to-back misses: the second must wait for ready to fall and rise again
    ldV(opc(6'h18, 5'd10, 5'd31, 16'h0060), 32'h8000_0054, 32'h60, 1'b0, 1'b0, 32'h0, 1'b0);
    ldV(opc(6'h18, 5'd10, 5'd31, 16'h0060), 32'h8000_0054, 32'h60, 1'b0, 1'b1, 32'h1111, 1'b0);
    ldV(opc(6'h18, 5'd11, 5'd31, 16'h0080), 32'h8000_0058, 32'h80, 1'b0, 1'b1, 32'h9999, 1'b1);
    ldV(opc(6'h18, 5'd11, 5'd31, 16'h0080), 32'h8000_0058, 32'h80, 1'b0, 1'b1, 32'h9999, 1'b1);
    ldV(opc(6'h18, 5'd11, 5'd31, 16'h0080), 32'h8000_0058, 32'h80, 1'b0, 1'b0, 32'h9999, 1'b1);
    ldV(opc(6'h18, 5'd11, 5'd31, 16'h0080), 32'h8000_0058, 32'h80, 1'b0, 1'b1, 32'h2222, 1'b0);
    stV(opc(6'h19, 5'd11, 5'd31, 16'h0024), 32'h8000_005C, 32'h24, 32'h2222, 1'b0, 1'b1, 1'b0);
    stV(opc(6'h19, 5'd10, 5'd31, 16'h0024), 32'h8000_0060, 32'h24, 32'h1111);

    // JMP to user mode, interrupt, illegal opcode, branches, LDR
    aluV(opc(6'h30, 5'd13, 5'd31, 16'h0100), 32'h8000_0064);
    aluV(opr(6'h1B, 5'd14, 5'd13, 5'd0), 32'h8000_0068);
    add(opc(6'h19, 5'd1, 5'd31, 16'h0010), 1'b1, 1'b0, 32'h0, 32'h0000_0100,
        1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    stV(opc(6'h19, 5'd30, 5'd31, 16'h0024), 32'h8000_0008, 32'h24, 32'h0000_0104, 1'b1);
    aluV(32'h0000_0000, 32'h8000_000C);
    stV(opc(6'h19, 5'd30, 5'd31, 16'h0024), 32'h8000_0004, 32'h24, 32'h8000_0010);
    stV(opc(6'h19, 5'd14, 5'd31, 16'h0024), 32'h8000_0008, 32'h24, 32'h8000_006C);
    aluV(opc(6'h1C, 5'd15, 5'd31, 16'hFFFF), 32'h8000_000C);
    aluV(opc(6'h1D, 5'd16, 5'd31, 16'hFFFF), 32'h8000_000C);
    stV(opc(6'h19, 5'd15, 5'd31, 16'h0024), 32'h8000_0010, 32'h24, 32'h8000_0010);
    stV(opc(6'h19, 5'd1, 5'd30, 16'h0010), 32'h8000_0014, 32'h8000_0020, 32'd5);
    ldV(opc(6'h1F, 5'd17, 5'd31, 16'h0001), 32'h8000_0018, 32'h8000_0020, 1'b1, 1'b0, 32'h0, 1'b0);
    stV(opc(6'h19, 5'd17, 5'd31, 16'h0024), 32'h8000_001C, 32'h24, 32'd5);

    // enter MISS_WAIT ahead of the reset below
    ldV(opc(6'h18, 5'd18, 5'd31, 16'h0044), 32'h8000_0020, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    ldV(opc(6'h18, 5'd18, 5'd31, 16'h0044), 32'h8000_0020, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    runTable();

    // reset in the middle of a miss
    reset = 1'b1;
    id = opc(6'h19, 5'd1, 5'd31, 16'h0010);
    #2;
    cmp("midmiss_reset_ia", ia, 32'h8000_0000);
    cmp("midmiss_reset_done", {31'b0, MemReadDone}, 32'h0);
    cmp("midmiss_reset_MemWrite", {31'b0, MemWrite}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    aluV(opc(6'h30, 5'd1, 5'd31, 16'd5), 32'h8000_0000);
    ldV(opc(6'h18, 5'd2, 5'd31, 16'h0010), 32'h8000_0004, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
    runTable();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/beta_cpu.md
Name: beta_cpu

Overview:
- Single-cycle 32-bit Beta (6.004 ISA) processor core with an internal 8-line direct-mapped, write-through data read cache.
- Loads that miss the cache stall the core through a 4-phase MemReadReady/MemReadDone handshake with external data memory.
- Instruction memory (imem5) and data memory (dmem5) are external, with combinational read.

Parameters:
- RESET_VEC, 32'h8000_0000, PC after reset.
- ILLOP_VEC, 32'h8000_0004, target for an illegal opcode.
- XADDR_VEC, 32'h8000_0008, interrupt target.
- CACHE_LINES, 8, number of one-word cache lines (power of 2).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- irq  in  1  external interrupt request, level.
- id  in  32  instruction word at ia.
- memReadData  in  32  data from external memory; valid while MemReadReady=1.
- MemReadReady  in  1  external memory has read data ready.
- ia  out  32  instruction address; bit 31 is the supervisor bit.
- memAddr  out  32  data address.
- memWriteData  out  32  store data (Rc contents).
- MemWrite  out  1  store strobe.
- MemRead  out  1  load strobe.
- MemReadDone  out  1  handshake acknowledge.
- MemHit  out  1  load hits the cache (combinational).

Behaviour:
- Reset, asynchronous: ia=RESET_VEC, state=RUN, MemReadDone=0, all cache valid bits cleared.
- While reset=1, MemWrite is forced to 0. The register file is not reset; R31 always reads 0 and writes to it are ignored.
- Supported opcodes:
  - LD 18, ST 19, JMP 1B, BEQ 1C, BNE 1D, LDR 1F.
  - ALU ops: ADD 20, SUB 21, MUL 22, CMPEQ 24, CMPLT 25, CMPLE 26, AND 28, OR 29, XOR 2A, SHL 2C, SHR 2D, SRA 2E.
  - Constant forms are opcode+10h and use sign-extended 16-bit lit.
- Any other opcode, including DIV, is illegal: R30 <- ia+4, ia <- ILLOP_VEC.
- Arithmetic: MUL keeps the low 32 bits. Shifts use b[4:0]. Compares produce 0 or 1, signed.
- Targets:
  - Branch/LDR target = ia+4+4*sext(lit).
  - JMP target = Ra & ~3, with bit31 = ia[31] & Ra[31].
  - JMP/BEQ/BNE write Rc <- ia+4.
  - Branches and the LDR target keep ia[31].
- Memory addressing: memAddr = Ra+sext(lit) for LD/ST, the branch target for LDR. MemRead=1 for LD/LDR; MemWrite=1 for ST.
- Interrupt: taken in RUN when irq=1 and ia[31]=0. The current instruction is suppressed (MemRead=MemWrite=0, no register write); R30 <- ia+4; ia <- XADDR_VEC. irq is ignored in MISS_WAIT.
- Cache:
  - Index memAddr[4:2], tag memAddr[31:5].
  - MemHit = MemRead & valid[idx] & tag match.
  - On a hit, the load completes in the same cycle using cache data.
  - A ST writes through and also updates/allocates the line: tag, data, valid=1.
- Load miss, RUN state with MemRead & !MemHit:
  - ia is held and the next state is MISS_WAIT.
  - ia, memAddr and MemRead stay stable during MISS_WAIT.
- MISS_WAIT: at the first rising edge with MemReadReady=1 and MemReadDone=0:
  - Rc <- memReadData.
  - Cache line filled.
  - ia advances to ia+4.
  - MemReadDone <- 1, state <- RUN.
- MemReadDone is registered. It stays 1 until the first rising edge where MemReadReady=0, then clears.
- MemReadReady is ignored while MemReadDone=1. A subsequent miss waits for the full 4-phase cycle, so stale ready is never accepted.
- Reset mid-miss: returns to RUN, the pending load is abandoned, and the cache is invalidated.

Decomposition:
- beta_pkg: opcode constants, the three vector constants, and the state enum {RUN, MISS_WAIT}.
- Sub-module beta_dcache: tag/data/valid arrays, hit logic, fill and write-update ports.
- Register file and ALU live inline in beta_cpu.

Test Plan:
- Reset release with id=ADDC(R31,5,R1), i.e. 0xC03F0005 -> ia=0x80000000, then 0x80000004, R1=5; MemRead=MemWrite=0.
- ST R1 to 0x10, then LD 0x10 -> MemWrite=1 with memAddr=0x10 and memWriteData=5. The LD gives MemHit=1 and completes in 1 cycle.
- LD from uncached 0x40 -> MemHit=0 and ia held. Assert MemReadReady after 5 cycles with data 0xDEAD -> MemReadDone=1, ia advances, Rc=0xDEAD. Done clears one edge after ready drops.
- Back-to-back miss loads -> the second load does not complete until MemReadReady has fallen and risen again.
- irq=1 with ia=0x00000100 -> ia=0x80000008, R30=0x00000104, no memory strobe. irq at ia[31]=1 is ignored.
- Opcode 0x00 -> ia=0x80000004 and R30=ia+4. BEQ with Ra=0 and lit=-1 -> ia unchanged (self-loop).
